floo_mcast_fork: RTL and testbench
==================================

// Module: floo_mcast_fork
// PURPOSE
// - Replicates one input flit stream onto NumOutput output streams according to a per-flit destination mask.
// - Provides unicast, partial-accept multicast and multi-flit (wormhole) bursts with the mask locked per packet.
// - Sits between a router input FIFO and the per-output wormhole arbiters, replacing inline served-mask logic.
// - Reusable by mesh, ring-on-mesh and tree multicast routers.
// PARAMETERS
// - NumOutput   5      number of output streams (>=2)
// - flit_t      logic  flit payload type (opaque, forwarded unchanged)
// - LoopbackIdx -1     if >=0, mask bit LoopbackIdx is forced to 0 (no loopback); -1 disables
// - CntWidth    16     width of each perf counter (only used with FLOO_MCAST_FORK_PERF_EN)
// PORTS
// - clk_i       in   1                     clock
// - rst_ni      in   1                     asynchronous active-low reset
// - valid_i     in   1                     input flit valid
// - ready_o     out  1                     input flit consumed (all required outputs served)
// - data_i      in   flit_t                input flit
// - mask_i      in   NumOutput             destination mask, sampled on head flits only
// - mcast_i     in   1                     1: replicate to all mask bits; 0: unicast (mask one-hot)
// - last_i      in   1                     last flit of packet
// - valid_o     out  NumOutput             per-output valid
// - ready_i     in   NumOutput             per-output ready
// - data_o      out  NumOutput x flit_t    per-output data (all copies of data_i)
// - busy_o      out  1                     1 while in BODY or served_q != 0
// - drop_o      out  1                     1-cycle pulse: head flit with empty effective mask dropped
// - perf_o      out  NumOutput x CntWidth  per-output handshake counts (macro only)
// BEHAVIOUR
// - Reset: state=HEAD, served_q=0, mask_q=0, mcast_q=0, perf counters=0; valid_o=0, busy_o=0, drop_o=0.
// - Effective mask m: HEAD -> mask_i & ~loop; BODY -> mask_q. Effective mode c: HEAD -> mcast_i; BODY -> mcast_q.
// - Combinational path from input to outputs; zero latency, no storage of flit data.
// - Unicast (c=0): valid_o[o] = valid_i & m[o]; ready_o = |(ready_i & m).
// - Multicast (c=1): valid_o[o] = valid_i & m[o] & ~served_q[o];
//   ready_o = &((ready_i & m) | ~m | served_q).
// - served_d = (valid_i & ready_o) ? 0 : served_q | (valid_o & ready_i); outputs accepted in an
//   earlier cycle are never re-presented for the same flit.
// - Empty m with valid_i in HEAD: ready_o=1, all valid_o=0, drop_o=1. State stays HEAD; the body
//   of a dropped multi-flit packet is dropped the same way, since its mask_i is empty too.
// - FSM HEAD -> BODY: input handshake with last_i=0 and m!=0; latch mask_q=m, mcast_q=c.
// - FSM BODY -> HEAD: input handshake with last_i=1. BODY -> BODY otherwise.
// - Single-flit packet (last_i=1 in HEAD): stays HEAD.
// - valid_o never depends on ready_i of the same output. ready_o depends combinationally on ready_i.
// - Upstream holds valid_i, data_i, mask_i, mcast_i and last_i stable until ready_o.
// - All outputs ready in the same cycle -> flit consumed in one cycle with served_q unchanged (0).
// - Reset asserted mid-packet: FSM and served_q cleared immediately; a partially served flit is
//   re-presented in full after reset.
// - Unicast with a non-one-hot mask is illegal; an assertion flags valid_i & ~c & ~$onehot0(m).
// CONFIGURATION
// - FLOO_MCAST_FORK_PERF_EN defined: perf_o present. perf_o[o] +1 on each valid_o[o]&ready_i[o];
//   saturates at 2^CntWidth-1; cleared only by reset.
// - Not defined: perf_o port and counters absent; all other behaviour identical.
// TESTING
// - Unicast, mask=5'b00100, all ready -> valid_o=5'b00100 same cycle; ready_o=1; busy_o=0.
// - Mcast, mask=5'b10110; ready_i=5'b00010 in cycle 0 -> served_q=5'b00010, ready_o=0.
//   Cycle 1, ready_i=5'b10100 -> valid_o=5'b10100; ready_o=1; served_q returns 0.
// - 3-flit mcast burst, head mask=5'b00011, body mask_i=5'b11100 -> all 3 flits reach outputs
//   0 and 1 only; FSM back to HEAD after the last handshake.
// - LoopbackIdx=2, head mask=5'b00100 -> drop_o pulses 1 cycle, ready_o=1, valid_o=0.
// - Reset pulse with served_q=5'b00001 mid-burst -> served_q=0, state=HEAD, busy_o=0 after reset.
// - PERF_EN, CntWidth=4: 20 handshakes on output 0 -> perf_o[0]=15 (saturated).

Source files
------------

// File: rtl/floo_mcast_fork.sv
// floo_mcast_fork: replicates one input flit stream onto NumOutput output
// streams under a per-packet destination mask. Supports unicast, partial-accept
// multicast with a served mask, and wormhole bursts with the mask locked at the head.
// Optional feature macro: FLOO_MCAST_FORK_PERF_EN (per-output handshake counters on perf_o).
module floo_mcast_fork #(
  parameter int unsigned NumOutput   = 5,
  parameter type         flit_t      = logic,
  parameter int          LoopbackIdx = -1,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  flit_t                data_i,
  input  logic [NumOutput-1:0] mask_i,
  input  logic                 mcast_i,
  input  logic                 last_i,
  output logic [NumOutput-1:0] valid_o,
  input  logic [NumOutput-1:0] ready_i,
  output flit_t                data_o [NumOutput],
`ifdef FLOO_MCAST_FORK_PERF_EN
  output logic [CntWidth-1:0]  perf_o [NumOutput],
`endif
  output logic                 busy_o,
  output logic                 drop_o
);

  localparam logic [0:0] ST_HEAD = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  // Elaboration-time parameter sanity.
  if (NumOutput < 2) begin : g_chk_num
    $error("floo_mcast_fork: NumOutput must be >= 2");
  end
  if (CntWidth < 1) begin : g_chk_cnt
    $error("floo_mcast_fork: CntWidth must be >= 1");
  end

  // Bit that is never a legal destination (the port the flit came in on).
  function automatic logic [NumOutput-1:0] loop_mask();
    logic [NumOutput-1:0] m;
    m = '0;
    for (int i = 0; i < NumOutput; i++) begin
      if (i == LoopbackIdx) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NumOutput-1:0] LoopMask = loop_mask();

  logic [0:0]           r_state;
  logic [NumOutput-1:0] r_served;
  logic [NumOutput-1:0] r_mask;
  logic                 r_mcast;

  logic                 w_head;
  logic [NumOutput-1:0] w_m;
  logic                 w_c;
  logic                 w_empty;
  logic                 w_fire;
  logic [NumOutput-1:0] w_served_d;

  // Effective mask/mode, per-output valid, input ready and served-mask update.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    w_head  = (r_state == ST_HEAD);
    w_m     = w_head ? (mask_i & ~LoopMask) : r_mask;
    w_c     = w_head ? mcast_i : r_mcast;
    w_empty = (w_m == '0);
    valid_o = {NumOutput{valid_i}} & w_m;
    ready_o = |(ready_i & w_m);
    if (w_c) begin
      // Outputs that already took this flit are not offered it again.
      valid_o = {NumOutput{valid_i}} & w_m & ~r_served;
      ready_o = &((ready_i & w_m) | ~w_m | r_served);
    end
    // A head with no destination is swallowed so the stream does not stall.
    if (w_head && w_empty) ready_o = 1'b1;
    drop_o     = valid_i & w_head & w_empty;
    w_fire     = valid_i & ready_o;
    w_served_d = w_fire ? '0 : (r_served | (valid_o & ready_i));
  end

  assign busy_o = (r_state == ST_BODY) || (r_served != '0);

  for (genvar o = 0; o < NumOutput; o++) begin : g_data
    assign data_o[o] = data_i;
  end

  // Packet FSM, locked mask/mode and served mask.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_HEAD;
      r_served <= '0;
      r_mask   <= '0;
      r_mcast  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update from the same pre-edge values.
      r_served <= w_served_d;
      if (w_fire) begin
        if (w_head && !last_i && !w_empty) begin
          r_state <= ST_BODY;
          r_mask  <= w_m;
          r_mcast <= w_c;
        end else if (!w_head && last_i) begin
          r_state <= ST_HEAD;
        end
      end
    end
  end

`ifdef FLOO_MCAST_FORK_PERF_EN
  localparam logic [CntWidth-1:0] CntMax = '1;
  logic [CntWidth-1:0] r_perf [NumOutput];

  // Saturating per-output handshake counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int o = 0; o < NumOutput; o++) r_perf[o] <= '0;
    end else begin
      for (int o = 0; o < NumOutput; o++) begin
        if (valid_o[o] && ready_i[o] && (r_perf[o] != CntMax)) r_perf[o] <= r_perf[o] + 1'b1;
      end
    end
  end

  assign perf_o = r_perf;
`endif

  // Unicast must name at most one destination.
  a_unicast_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !w_c) |-> $onehot0(w_m));

endmodule

// File: tb/tb_floo_mcast_fork.sv
// tb_floo_mcast_fork: directed vector table plus hand-written multi-cycle
// sequences for floo_mcast_fork (default instance and a LoopbackIdx=2 instance).
module tb_floo_mcast_fork;

  localparam int N = 5;
  typedef logic [7:0] flit_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i, mcast_i, last_i;
  flit_t        data_i;
  logic [N-1:0] mask_i, ready_i;

  logic         ready_o, busy_o, drop_o;
  logic [N-1:0] valid_o;
  flit_t        data_o [N];
  logic         lb_ready_o, lb_busy_o, lb_drop_o;
  logic [N-1:0] lb_valid_o;
  flit_t        lb_data_o [N];
`ifdef FLOO_MCAST_FORK_PERF_EN
  logic [3:0]   perf_o [N];
  logic [3:0]   lb_perf_o [N];
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  floo_mcast_fork #(.NumOutput(N), .flit_t(flit_t), .LoopbackIdx(-1), .CntWidth(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .mask_i(mask_i), .mcast_i(mcast_i), .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o),
`ifdef FLOO_MCAST_FORK_PERF_EN
    .perf_o(perf_o),
`endif
    .busy_o(busy_o), .drop_o(drop_o));

  floo_mcast_fork #(.NumOutput(N), .flit_t(flit_t), .LoopbackIdx(2), .CntWidth(4)) u_lb (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(lb_ready_o), .data_i(data_i),
    .mask_i(mask_i), .mcast_i(mcast_i), .last_i(last_i), .valid_o(lb_valid_o), .ready_i(ready_i),
    .data_o(lb_data_o),
`ifdef FLOO_MCAST_FORK_PERF_EN
    .perf_o(lb_perf_o),
`endif
    .busy_o(lb_busy_o), .drop_o(lb_drop_o));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic mc, input logic [N-1:0] m, input logic l,
                       input logic [N-1:0] r, input flit_t d);
    valid_i = v; mcast_i = mc; mask_i = m; last_i = l; ready_i = r; data_i = d;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle HEAD vectors (last=1, served mask idle before each).
  typedef struct {
    string        name;
    logic         v;
    logic         mc;
    logic [N-1:0] m;
    logic [N-1:0] r;
    flit_t        d;
    logic [N-1:0] exp_valid;
    logic         exp_ready;
    logic         exp_drop;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"idle",        1'b0, 1'b0, 5'b00100, 5'b11111, 8'h11, 5'b00000, 1'b1, 1'b0};
    vecs[1] = '{"uni_all_rdy", 1'b1, 1'b0, 5'b00100, 5'b11111, 8'h22, 5'b00100, 1'b1, 1'b0};
    vecs[2] = '{"uni_blocked", 1'b1, 1'b0, 5'b00100, 5'b11011, 8'h33, 5'b00100, 1'b0, 1'b0};
    vecs[3] = '{"mc_all",      1'b1, 1'b1, 5'b11111, 5'b11111, 8'h44, 5'b11111, 1'b1, 1'b0};
    vecs[4] = '{"mc_none_rdy", 1'b1, 1'b1, 5'b01001, 5'b00000, 8'h55, 5'b01001, 1'b0, 1'b0};
    vecs[5] = '{"uni_empty",   1'b1, 1'b0, 5'b00000, 5'b00000, 8'h66, 5'b00000, 1'b1, 1'b1};
    vecs[6] = '{"mc_empty",    1'b1, 1'b1, 5'b00000, 5'b11111, 8'h77, 5'b00000, 1'b1, 1'b1};
    vecs[7] = '{"uni_top",     1'b1, 1'b0, 5'b10000, 5'b10000, 8'h88, 5'b10000, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 8'h00);
    #12;
    check("rst_busy", busy_o, 0);
    check("rst_drop", drop_o, 0);
    check("rst_valid", valid_o, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].mc, vecs[i].m, 1'b1, vecs[i].r, vecs[i].d);
      #2;
      check({vecs[i].name, "_valid"}, valid_o, vecs[i].exp_valid);
      check({vecs[i].name, "_ready"}, ready_o, vecs[i].exp_ready);
      check({vecs[i].name, "_drop"},  drop_o,  vecs[i].exp_drop);
      check({vecs[i].name, "_data"},  data_o[i % N], vecs[i].d);
      tick();
      check({vecs[i].name, "_busy"},  busy_o, 0);
    end

    // Partial-accept multicast over two cycles.
    drive(1'b1, 1'b1, 5'b10110, 1'b1, 5'b00010, 8'hA0);
    #2;
    check("pmc_c0_valid", valid_o, 5'b10110);
    check("pmc_c0_ready", ready_o, 0);
    tick();
    check("pmc_c0_busy", busy_o, 1);
    ready_i = 5'b10100;
    #2;
    check("pmc_c1_valid", valid_o, 5'b10100);
    check("pmc_c1_ready", ready_o, 1);
    tick();
    check("pmc_c1_busy", busy_o, 0);

    // 3-flit multicast burst: mask locked at head, body mask_i ignored.
    drive(1'b1, 1'b1, 5'b00011, 1'b0, 5'b11111, 8'hB0);
    #2;
    check("bst_head_valid", valid_o, 5'b00011);
    check("bst_head_ready", ready_o, 1);
    tick();
    check("bst_head_busy", busy_o, 1);
    drive(1'b1, 1'b0, 5'b11100, 1'b0, 5'b00001, 8'hB1);
    #2;
    check("bst_b1_valid", valid_o, 5'b00011);
    check("bst_b1_ready", ready_o, 0);
    check("bst_b1_data", data_o[1], 8'hB1);
    tick();
    ready_i = 5'b00011;
    #2;
    check("bst_b1_reoffer", valid_o, 5'b00010);
    check("bst_b1_ready2", ready_o, 1);
    tick();
    check("bst_b1_busy", busy_o, 1);
    drive(1'b1, 1'b0, 5'b11100, 1'b1, 5'b11111, 8'hB2);
    #2;
    check("bst_last_valid", valid_o, 5'b00011);
    check("bst_last_ready", ready_o, 1);
    tick();
    check("bst_last_busy", busy_o, 0);
    drive(1'b1, 1'b0, 5'b00100, 1'b1, 5'b00000, 8'hB3);
    #2;
    check("bst_new_head", valid_o, 5'b00100);
    tick();

    // Loopback suppression: only the LoopbackIdx=2 instance drops.
    drive(1'b1, 1'b0, 5'b00100, 1'b1, 5'b11111, 8'hC0);
    #2;
    check("lb_drop", lb_drop_o, 1);
    check("lb_ready", lb_ready_o, 1);
    check("lb_valid", lb_valid_o, 0);
    check("lb_ref_valid", valid_o, 5'b00100);
    tick();
    valid_i = 1'b0;
    #2;
    check("lb_drop_pulse_end", lb_drop_o, 0);
    tick();

    // Reset mid-burst with a partially served body flit.
    drive(1'b1, 1'b1, 5'b00011, 1'b0, 5'b11111, 8'hD0);
    tick();
    drive(1'b1, 1'b1, 5'b11100, 1'b0, 5'b00001, 8'hD1);
    tick();
    check("rstm_busy_before", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("rstm_busy_in_rst", busy_o, 0);
    valid_i = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("rstm_busy_after", busy_o, 0);
    drive(1'b1, 1'b1, 5'b00011, 1'b0, 5'b00000, 8'hD0);
    #2;
    check("rstm_full_reoffer", valid_o, 5'b00011);
    valid_i = 1'b0;
    tick();

`ifdef FLOO_MCAST_FORK_PERF_EN
    // Counter saturation at 2^4-1.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("perf_rst", perf_o[0], 0);
    drive(1'b1, 1'b0, 5'b00001, 1'b1, 5'b00001, 8'hE0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 9) check("perf_10", perf_o[0], 10);
    end
    valid_i = 1'b0;
    #2;
    check("perf_sat", perf_o[0], 15);
    check("perf_other", perf_o[1], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
